// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between two pipeline stages: upstream offer, downstream stall,
// held-word outputs and the fence-stall request/response pair.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 160,
  parameter int PC_W   = 32
);
  // Handshake: a word transfers on a rising edge when up_valid & up_ready & ~bubble_req
  // and flush is low; dn_valid/dn_data/dn_pc are consumed on any edge where dn_stall is low.
  logic              up_valid;
  logic [DATA_W-1:0] up_data;
  logic [PC_W-1:0]   up_pc;
  logic              up_ready;
  logic              bubble_req;
  logic              flush;
  logic              dn_stall;
  logic              dn_valid;
  logic [DATA_W-1:0] dn_data;
  logic [PC_W-1:0]   dn_pc;
  logic [1:0]        occupancy;
  logic              fence_req;
  logic              fence_stall;

  modport master (
    output up_valid, up_data, up_pc, bubble_req, flush, dn_stall, fence_req,
    input  up_ready, dn_valid, dn_data, dn_pc, occupancy, fence_stall
  );

  modport slave (
    input  up_valid, up_data, up_pc, bubble_req, flush, dn_stall, fence_req,
    output up_ready, dn_valid, dn_data, dn_pc, occupancy, fence_stall
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline register with stall hold, flush, bubble insertion, optional 2-entry skid
// buffer (registered up_ready) and a fence-stall window extender.
module pipe_stage_skid #(
  parameter int                DATA_W    = 160,
  parameter int                PC_W      = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int                SKID      = 1,
  parameter int                FENCE_EXT = 4
) (
  input logic               clk,
  input logic               cpurst,
  pipe_stage_skid_if.slave  bus
);
  logic              m_valid, s_valid;
  logic [DATA_W-1:0] m_data, s_data;
  logic [PC_W-1:0]   m_pc, s_pc;
  logic              up_ready;
  logic              accept;

  // With the skid buffer, ready depends only on registered state.
  assign up_ready = (SKID != 0) ? ~s_valid : ~bus.dn_stall;
  assign accept   = bus.up_valid & up_ready & ~bus.bubble_req;

  always_ff @(posedge clk) begin
    if (cpurst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= NOP_VALUE;
      s_data  <= NOP_VALUE;
      m_pc    <= '0;
      s_pc    <= '0;
    end else if (bus.flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= NOP_VALUE;
    end else if (!bus.dn_stall) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_data  <= s_data;
        m_pc    <= s_pc;
        s_valid <= 1'b0;
      end else if (bus.bubble_req) begin
        m_valid <= 1'b0;
        m_data  <= NOP_VALUE;
        m_pc    <= bus.up_pc;
      end else if (accept) begin
        m_valid <= 1'b1;
        m_data  <= bus.up_data;
        m_pc    <= bus.up_pc;
      end else begin
        m_valid <= 1'b0;
        m_data  <= NOP_VALUE;
      end
    end else if ((SKID != 0) && accept) begin
      // Stalled: the new word lands behind M, or in M if M is empty.
      if (m_valid) begin
        s_valid <= 1'b1;
        s_data  <= bus.up_data;
        s_pc    <= bus.up_pc;
      end else begin
        m_valid <= 1'b1;
        m_data  <= bus.up_data;
        m_pc    <= bus.up_pc;
      end
    end
  end

  assign bus.up_ready  = up_ready;
  assign bus.dn_valid  = m_valid;
  assign bus.dn_data   = m_data;
  assign bus.dn_pc     = m_pc;
  assign bus.occupancy = {1'b0, m_valid} + {1'b0, s_valid};

  generate
    if (FENCE_EXT > 0) begin : g_fence
      localparam int              CNT_W    = $clog2(FENCE_EXT + 1);
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FENCE_EXT - 1);
      logic             ext;
      logic [CNT_W-1:0] cnt;

      // The window closes on its own count; fence_req inside it does not retrigger.
      always_ff @(posedge clk) begin
        if (cpurst) begin
          ext <= 1'b0;
        end else if (ext && (cnt == CNT_LAST)) begin
          ext <= 1'b0;
        end else if (bus.fence_req) begin
          ext <= 1'b1;
        end

        if (cpurst || !ext) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign bus.fence_stall = bus.fence_req | ext;
    end else begin : g_no_fence
      assign bus.fence_stall = bus.fence_req;
    end
  endgenerate
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed decode→execute pipeline register.
- Moves one opaque payload word plus a PC between two pipeline stages with valid/ready flow control.
- Supports downstream stall hold, flush, bubble insertion and an optional 2-entry skid buffer, so upstream ready is registered.
- Includes a parametrised fence-stall extender. Instantiated between decode/execute and execute/memory stages.

Parameters:
- DATA_W, 160: payload width (packed control + operand fields).
- PC_W, 32: PC width.
- NOP_VALUE, {DATA_W{1'b0}}: payload loaded on reset, flush or bubble.
- SKID, 1: 1 = 2-entry skid buffer (registered up_ready); 0 = single register, up_ready = ~dn_stall.
- FENCE_EXT, 4: cycles fence_stall is extended after fence_req; 0 disables the extender.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- cpurst  in  1  synchronous active-high reset.
- up_valid  in  1  upstream word valid.
- up_data  in  DATA_W  upstream payload.
- up_pc  in  PC_W  upstream PC.
- up_ready  out  1  stage can accept a word this cycle.
- bubble_req  in  1  insert NOP instead of the upstream word (decode hazard).
- flush  in  1  discard all held words (exception/redirect).
- dn_stall  in  1  downstream not consuming (exe/memacc stall).
- dn_valid  out  1  main entry valid.
- dn_data  out  DATA_W  main entry payload.
- dn_pc  out  PC_W  main entry PC.
- occupancy  out  2  held valid entries, 0..2.
- fence_req  in  1  fence decoded this cycle.
- fence_stall  out  1  fence_req | extended fence stall.

Behaviour:
- State:
  - Main entry M: valid, data, pc.
  - Skid entry S: valid, data, pc; exists only when SKID=1.
  - Fence logic: ext flag and cnt counter, cnt width clog2(FENCE_EXT+1).
- Output mapping: dn_* = M fields. occupancy = M.valid + S.valid.
- Reset (cpurst):
  - M.valid = S.valid = 0; M.data = S.data = NOP_VALUE; M.pc = S.pc = 0.
  - ext = 0, cnt = 0.
  - up_ready = 1 the cycle after reset.
- Priority each edge: cpurst > flush > bubble/normal.
- flush:
  - M.valid and S.valid ← 0; M.data ← NOP_VALUE; pc fields hold.
  - Upstream word offered in the same cycle is dropped, even if up_ready = 1.
  - dn_stall is ignored.
- up_ready:
  - SKID=1: up_ready = ~S.valid (registered state only, no combinational path from dn_stall).
  - SKID=0: up_ready = ~dn_stall.
- Accept: accept = up_valid & up_ready & ~bubble_req.
- dn_stall = 0 (advance):
  - If S.valid: M ← S, S.valid ← 0; an upstream word is not accepted this cycle (up_ready = 0).
  - Else if bubble_req: M.valid ← 0, M.data ← NOP_VALUE, M.pc ← up_pc.
  - Else if accept: M ← {1, up_data, up_pc}.
  - Else: M.valid ← 0, M.data ← NOP_VALUE, M.pc holds.
- dn_stall = 1 (hold):
  - M holds; bubble_req has no effect.
  - SKID=1 and accept: if M.valid, S ← {1, up_data, up_pc}; otherwise M ← {1, up_data, up_pc}.
  - SKID=0: nothing accepted.
- Ordering: no word is ever duplicated or reordered; the S word always leaves before any newer word.
- Latency: an accepted word appears on dn_* one cycle after acceptance when M is free; otherwise it follows M in order.
- Fence extender (FENCE_EXT = N > 0):
  - ext: if cpurst → 0; elif cnt == N−1 → 0; elif fence_req → 1.
  - cnt: if cpurst | ~ext → 0; else cnt+1.
  - A single-cycle fence_req gives fence_stall high for 1+N consecutive cycles.
  - fence_req during ext does not retrigger the window; fence_stall stays high through fence_req itself.
  - N = 0: fence_stall = fence_req, ext/cnt tied to 0.
- Reset mid-operation: cpurst in any cycle discards M/S and terminates a fence window immediately (fence_stall = fence_req the next cycle).

Test Plan:
- Reset then stream, SKID=1: words A,B,C with dn_stall=0 → dn_valid rises one cycle after each acceptance, data A,B,C in order, occupancy ≤ 1, up_ready stays 1.
- Stall with skid, SKID=1: M=A, dn_stall=1, offer B → S=B, occupancy=2, up_ready=0 next cycle. Release dn_stall → dn_data=A, then B, then up_ready=1. C offered during the full state is not lost.
- Bubble: bubble_req=1, dn_stall=0, up_data=0x5 → dn_valid=0, dn_data=NOP_VALUE, dn_pc=up_pc. With dn_stall=1 the same bubble leaves M unchanged.
- Flush with occupancy=2, up_valid=1 → next cycle occupancy=0, dn_valid=0, dn_data=NOP_VALUE, up_ready=1, offered word dropped.
- Fence, FENCE_EXT=4: 1-cycle fence_req at cycle 10 → fence_stall high cycles 10–14, low at 15. Repeat with fence_req held cycles 10–12 → window still ends at 14. FENCE_EXT=0 → fence_stall mirrors fence_req.
- SKID=0, dn_stall toggling 1,0,1,0 with continuous up_valid → up_ready equals ~dn_stall each cycle, no loss, occupancy never 2. cpurst asserted during fence window → fence_stall low next cycle.
